clock_en_gen: RTL and testbench
===============================

# clock_en_gen

Parametrised multi-channel clock-enable generator for the single system clock domain. Each channel divides the base clock by a run-time programmable ratio and emits a one-cycle enable pulse per period. A per-channel settle counter gives PLL-style lock semantics: after any ratio change the channel reports unlocked and suppresses pulses for a fixed number of cycles. Slower subsystems (cog timing, serial, counters) use these enables instead of derived clocks.

## Interface
- CHANNELS, 2, number of independent enable channels (1..16)
- DIV_W, 8, width of divide ratio
- SETTLE_CYCLES, 16, cycles a channel stays unlocked after a ratio change (0 = lock immediately)
- CH_W, $clog2(CHANNELS) (minimum 1), width of channel select (derived, not overridden)

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  request can be accepted this cycle
- cfg_chan  in  CH_W  target channel
- cfg_div  in  DIV_W  new ratio; 0 = channel off
- en_out  out  CHANNELS  per-channel one-cycle enable pulse
- locked  out  CHANNELS  channel running and settled

## Operation
- Per-channel state: div (DIV_W), cnt (DIV_W), settle counter, pending flag, pending ratio.
- Reset (sampled at rising edge): div=0, cnt=0, settle=0, pending=0 for all channels. Outputs: en_out=0, locked=0, cfg_ready=1.
- cfg_ready = ~pending[cfg_chan]; out-of-range cfg_chan -> cfg_ready=0, nothing accepted.
- Accept on cfg_valid & cfg_ready: pending[cfg_chan]=1, pending ratio=cfg_div, visible the next cycle.
- Counter: when div!=0, cnt counts 0..div-1 and wraps to 0; when div=0, cnt held at 0.
- Boundary: div=0, or cnt==div-1.
- Apply: on a cycle where pending=1 and the channel is at a boundary: div<=pending ratio, cnt<=0, settle<=SETTLE_CYCLES, pending<=0.
- Settle: when nonzero, decrements by 1 per cycle regardless of div.
- locked[i] = (div!=0) & (settle==0), derived from registers only.
- en_out[i] = locked[i] & (cnt==div-1), derived from registers only, glitch-free, exactly one cycle wide per period.
- Pulse at the boundary on which a new ratio is applied still fires if the old ratio was locked. The old period always completes.
- Channels are fully independent. A pending on one channel never blocks another.
- Writing the same ratio as current is still a change: it restarts settle.
- Writing 0: at the next boundary the channel goes off and locked drops. Off channels ignore settle.

## Timing
- Config accepted at cycle T: pending visible T+1.
- Off channel: apply at T+1, new div visible T+2, settle=S at T+2, locked=1 at T+2+S.
- First en_out after lock: at the first cycle ≥ T+2+S with cnt==div-1. cnt is free-running from 0 at T+2.
- Running channel: apply at the first boundary ≥ T+1. Worst-case latency to the new ratio is the old div+1 cycles.
- div=1: cnt stays 0 and every cycle is a boundary. Once locked, en_out is high every cycle.
- div=2^DIV_W-1 is the longest period. No overflow: cnt never exceeds div-1.
- Reset mid-operation (mid-settle, mid-period, pending set): all state cleared at that edge. A request presented in the reset cycle is dropped.

## Test plan
- Reset with CHANNELS=2, DIV_W=8, SETTLE_CYCLES=4 -> en_out=00, locked=00, cfg_ready=1; no pulses for 50 cycles.
- Write ch0 div=4 at T -> locked[0] rises T+6; en_out[0] pulses T+9, T+13, T+17 (period 4); ch1 stays 0.
- Write ch1 div=1 -> after 4-cycle settle en_out[1] high every cycle; locked[1]=1; ch0 pulses unaffected.
- With ch0 div=4 locked, write div=2 mid-period -> cfg_ready low for ch0 until boundary; the old boundary pulse fires; locked[0] low 4 cycles; then en_out[0] every 2 cycles.
- With ch0 pending, request ch0 again -> not accepted (cfg_ready=0). Request ch1 the same cycle -> accepted. Write div=0 to ch0 -> off at the next boundary, locked[0]=0, no further pulses.
- Assert reset during ch0 settle with ch1 pending -> next cycle all outputs 0, cfg_ready=1. Rewrite ch0 div=3 -> normal lock after 4 cycles.

Source files
------------

// File: rtl/clock_en_gen.sv
// clock_en_gen: multi-channel programmable clock-enable generator. Each channel
// divides the system clock and holds off its pulses for a settle window after a ratio change.
module clock_en_gen #(
    parameter int  CHANNELS      = 2,
    parameter int  DIV_W         = 8,
    parameter int  SETTLE_CYCLES = 16,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] en_out,
    output logic [CHANNELS-1:0] locked
);
    localparam int               SET_W       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

    logic [DIV_W-1:0]    div_q    [CHANNELS];
    logic [DIV_W-1:0]    div_d    [CHANNELS];
    logic [DIV_W-1:0]    cnt_q    [CHANNELS];
    logic [DIV_W-1:0]    cnt_d    [CHANNELS];
    logic [SET_W-1:0]    settle_q [CHANNELS];
    logic [SET_W-1:0]    settle_d [CHANNELS];
    logic [DIV_W-1:0]    pdiv_q   [CHANNELS];
    logic [DIV_W-1:0]    pdiv_d   [CHANNELS];
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] pend_d;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] apply;

    // Last count of a running period; an off channel (div=0) never has one.
    function automatic logic is_last(input logic [DIV_W-1:0] div, input logic [DIV_W-1:0] cnt);
        return (div != '0) && (cnt == div - DIV_ONE);
    endfunction

    // Out-of-range channel numbers match no channel and leave cfg_ready low.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CH_W'(i)) begin
                cfg_ready = ~pend_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));
            apply[i]  = pend_q[i] && ((div_q[i] == '0) || is_last(div_q[i], cnt_q[i]));

            pend_d[i] = pend_q[i];
            pdiv_d[i] = pdiv_q[i];
            if (accept[i]) begin
                pend_d[i] = 1'b1;
                pdiv_d[i] = cfg_div;
            end else if (apply[i]) begin
                pend_d[i] = 1'b0;
            end

            div_d[i]    = div_q[i];
            cnt_d[i]    = '0;
            settle_d[i] = (settle_q[i] != '0) ? settle_q[i] - SET_ONE : settle_q[i];
            if (apply[i]) begin
                div_d[i]    = pdiv_q[i];
                settle_d[i] = SETTLE_INIT;
            end else if ((div_q[i] != '0) && !is_last(div_q[i], cnt_q[i])) begin
                cnt_d[i] = cnt_q[i] + DIV_ONE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            locked[i] = (div_q[i] != '0) && (settle_q[i] == '0);
            en_out[i] = (settle_q[i] == '0) && is_last(div_q[i], cnt_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i]    <= '0;
                cnt_q[i]    <= '0;
                settle_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i]    <= div_d[i];
                cnt_q[i]    <= cnt_d[i];
                settle_q[i] <= settle_d[i];
            end
            pend_q <= pend_d;
        end
        // Pending ratio is only meaningful while pend_q is set, so it needs no reset.
        for (int i = 0; i < CHANNELS; i++) begin
            pdiv_q[i] <= pdiv_d[i];
        end
    end
endmodule

// File: tb/tb_clock_en_gen.sv
// Directed bench for clock_en_gen with CHANNELS=2, DIV_W=8, SETTLE_CYCLES=4.
module tb_clock_en_gen;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [0:0] cfg_chan = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [1:0] en_out;
    logic [1:0] locked;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0, t1, tw, tz, tb, tc;

    clock_en_gen #(.CHANNELS(2), .DIV_W(8), .SETTLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .en_out(en_out), .locked(locked)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // ch0 after the first div=4 write at t0: locked from t0+6, cnt=0 at t0+2.
    function automatic logic e0_div4(input int c);
        return ((c - t0) >= 6) && (((c - t0 - 2) % 4) == 3);
    endfunction

    initial begin
        // Reset and idle
        step();
        step();
        reset = 1'b0;
        cfg_chan = 1'b0;
        #1;
        chk("rst_en", 8'(en_out), 8'd0);
        chk("rst_locked", 8'(locked), 8'd0);
        chk("rst_ready", 8'(cfg_ready), 8'd1);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("idle_en", 8'(en_out), 8'd0);
            chk("idle_locked", 8'(locked), 8'd0);
        end

        // ch0 div=4 from off: locked at T+6, pulses T+9, T+13, T+17
        t0 = cyc;
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd4;
        #1;
        chk("wr0_ready", 8'(cfg_ready), 8'd1);
        step();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            chk("ch0_locked", 8'(locked), 8'({1'b0, (k >= 6)}));
            chk("ch0_en", 8'(en_out), 8'({1'b0, e0_div4(cyc)}));
            step();
        end

        // ch1 div=1: every cycle once settled, ch0 unaffected
        t1 = cyc;
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_div = 8'd1;
        #1;
        chk("wr1_ready", 8'(cfg_ready), 8'd1);
        step();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("div1_locked", 8'(locked), 8'({(k >= 6), 1'b1}));
            chk("div1_en", 8'(en_out), 8'({(k >= 6), e0_div4(cyc)}));
            step();
        end

        // ch0 div=4 -> 2 written mid-period (cnt=1)
        for (int k = 0; k < 4 && ((cyc - t0 - 2) % 4) != 1; k++) step();
        tw = cyc;
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd2;
        #1;
        chk("chg_ready", 8'(cfg_ready), 8'd1);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("chg_pend_ready1", 8'(cfg_ready), 8'd0);
        chk("chg_en1", 8'(en_out), 8'b10);
        step();
        chk("chg_pend_ready2", 8'(cfg_ready), 8'd0);
        chk("chg_old_pulse", 8'(en_out), 8'b11);
        chk("chg_old_locked", 8'(locked), 8'b11);
        step();
        chk("chg_ready_back", 8'(cfg_ready), 8'd1);
        for (int k = 3; k <= 12; k++) begin
            chk("chg_locked", 8'(locked), 8'({1'b1, (k >= 7)}));
            chk("chg_en", 8'(en_out), 8'({1'b1, (k >= 7) && (((k - 3) % 2) == 1)}));
            step();
        end
        step();

        // ch0 off with a blocked second request; ch1 accepted meanwhile
        tz = cyc;
        chk("off_pre_en", 8'(en_out), 8'b11);
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd0;
        #1;
        chk("off_ready", 8'(cfg_ready), 8'd1);
        step();
        cfg_div = 8'd5;
        #1;
        chk("dup_ready", 8'(cfg_ready), 8'd0);
        chk("dup_en", 8'(en_out), 8'b10);
        step();
        chk("dup_ready2", 8'(cfg_ready), 8'd0);
        cfg_chan = 1'b1; cfg_div = 8'd3;
        #1;
        chk("other_ready", 8'(cfg_ready), 8'd1);
        chk("off_last_pulse", 8'(en_out), 8'b11);
        step();
        cfg_valid = 1'b0;
        for (int k = 3; k <= 18; k++) begin
            chk("off_locked", 8'(locked), 8'({(k <= 3) || (k >= 8), 1'b0}));
            chk("off_en", 8'(en_out), 8'({(k == 3) || ((k >= 8) && (((k - 4) % 3) == 2)), 1'b0}));
            step();
        end

        // Reset during ch0 settle with ch1 pending; request in reset cycle dropped
        for (int k = 0; k < 3 && ((cyc - tz - 4) % 3) != 2; k++) step();
        tb = cyc;
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd3;
        step();
        cfg_chan = 1'b1; cfg_div = 8'd7;
        step();
        cfg_valid = 1'b0;
        #1;
        chk("prerst_pend1", 8'(cfg_ready), 8'd0);
        chk("prerst_locked", 8'(locked), 8'b10);
        reset = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd5;
        step();
        reset = 1'b0;
        cfg_valid = 1'b0;
        chk("mrst_en", 8'(en_out), 8'd0);
        chk("mrst_locked", 8'(locked), 8'd0);
        cfg_chan = 1'b1;
        #1;
        chk("mrst_ready1", 8'(cfg_ready), 8'd1);
        cfg_chan = 1'b0;
        #1;
        chk("mrst_ready0", 8'(cfg_ready), 8'd1);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("mrst_idle_locked", 8'(locked), 8'd0);
            chk("mrst_idle_en", 8'(en_out), 8'd0);
        end

        // Rewrite ch0 div=3: locked T+6, pulses T+7, T+10
        tc = cyc;
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_div = 8'd3;
        #1;
        chk("rw_ready", 8'(cfg_ready), 8'd1);
        step();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk("rw_locked", 8'(locked), 8'({1'b0, (k >= 6)}));
            chk("rw_en", 8'(en_out), 8'({1'b0, (k >= 6) && (((k - 2) % 3) == 2)}));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
